// File: rtl/mark_result_streamer_pkg.sv
// Shared constants, state encoding and helpers for the Golomb result streamer.
package mark_result_streamer_pkg;

    // Default width of one mark value.
    localparam int MARKWIDTH = 9;

    // First byte of every frame, lets the host resynchronise.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Frame sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        HDR2    = 3'd3,
        MARK_HI = 3'd4,
        MARK_LO = 3'd5,
        CKSUM   = 3'd6
    } state_t;

    // Bytes in a frame carrying n results of (numpositions+1) marks each.
    function automatic int frame_len(input int numpositions, input int n);
        return 4 + 2 * (numpositions + 1) * n;
    endfunction

endpackage

// File: rtl/mark_result_streamer_snapshot_mux.sv
// Selects one mark out of the captured result vector by (result, mark) index.
// Result 1 sits in the MSBs of the vector and mark 0 in the MSBs of each
// result; out-of-range indices return zero.
module mark_snapshot_mux
    import mark_result_streamer_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10,
    parameter int MARKWIDTH    = mark_result_streamer_pkg::MARKWIDTH,
    parameter int RW           = 6,
    parameter int KW           = 3
) (
    input  logic [(NUMPOSITIONS+1)*MARKWIDTH*NUMRESULTS-1:0] snap,
    input  logic [RW-1:0]                                    r,
    input  logic [KW-1:0]                                    k,
    output logic [MARKWIDTH-1:0]                             mark
);

    localparam int MARKS_PER = NUMPOSITIONS + 1;
    localparam int NUMMARKS  = MARKS_PER * NUMRESULTS;

    int idx;

    // Flatten (r, k) to a mark ordinal counted from the MSB end and shift it down.
    always_comb begin
        idx  = (int'(r) - 1) * MARKS_PER + int'(k);
        mark = '0;
        if (r != '0 && idx < NUMMARKS) begin
            mark = MARKWIDTH'(snap >> ((NUMMARKS - 1 - idx) * MARKWIDTH));
        end
    end

endmodule

// File: rtl/mark_result_streamer.sv
// Captures the search results on a rising `done` and streams them to the host
// as a framed byte sequence over a valid/ready interface:
//   A5, n, marks-per-result, {mark_hi, mark_lo} per mark, checksum.
module mark_result_streamer
    import mark_result_streamer_pkg::*;
#(
    parameter int NUMPOSITIONS = 5,
    parameter int NUMRESULTS   = 10,
    parameter int MARKWIDTH    = mark_result_streamer_pkg::MARKWIDTH
) (
    input  logic                                             clock,
    input  logic                                             reset,
    input  logic                                             done,
    input  logic [5:0]                                       numResults,
    input  logic [(NUMPOSITIONS+1)*MARKWIDTH*NUMRESULTS-1:0] results,
    output logic [7:0]                                       tx_data,
    output logic                                             tx_valid,
    input  logic                                             tx_ready,
    output logic                                             busy,
    output logic                                             frame_sent,
    output logic                                             missed
);

    localparam int TOTALW = (NUMPOSITIONS + 1) * MARKWIDTH * NUMRESULTS;
    localparam int KW     = (NUMPOSITIONS < 1) ? 1 : $clog2(NUMPOSITIONS + 1);

    localparam logic [5:0]    NMAX             = 6'(NUMRESULTS);
    localparam logic [KW-1:0] KLAST            = KW'(NUMPOSITIONS);
    localparam logic [7:0]    MARKS_PER_RESULT = 8'(NUMPOSITIONS + 1);

    state_t                state;
    logic                  done_q;
    logic                  rise;
    logic                  xfer;
    logic                  capture;
    logic [5:0]            n_clamp;
    logic [TOTALW-1:0]     snap;
    logic [5:0]            n_q;
    logic [5:0]            r_q;
    logic [KW-1:0]         k_q;
    logic [7:0]            csum_q;
    logic [7:0]            csum_next;
    logic [MARKWIDTH-1:0]  mark;
    logic [15:0]           mark16;

    assign rise      = done & ~done_q;
    assign xfer      = tx_valid & tx_ready;
    assign capture   = rise && (state == IDLE);
    assign n_clamp   = (numResults > NMAX) ? NMAX : numResults;
    assign mark16    = 16'(mark);
    // Running sum including the byte being accepted this cycle.
    assign csum_next = csum_q + tx_data;

    mark_snapshot_mux #(
        .NUMPOSITIONS (NUMPOSITIONS),
        .NUMRESULTS   (NUMRESULTS),
        .MARKWIDTH    (MARKWIDTH),
        .RW           (6),
        .KW           (KW)
    ) u_mux (
        .snap (snap),
        .r    (r_q),
        .k    (k_q),
        .mark (mark)
    );

    // Snapshot of the result vector and clamped count, frozen for the whole frame.
    always_ff @(posedge clock) begin
        if (capture) begin
            snap <= results;
            n_q  <= n_clamp;
        end
    end

    // Frame sequencer: every advance happens on an accepted byte, and the byte
    // for the next state is loaded into tx_data on that same edge. The mark
    // indices step on the MARK_HI transfer so that during MARK_LO they already
    // point at the next mark; r_q passing n_q marks the end of the marks.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            tx_data    <= 8'h00;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            frame_sent <= 1'b0;
            missed     <= 1'b0;
            r_q        <= 6'd0;
            k_q        <= '0;
            csum_q     <= 8'h00;
        end else begin
            done_q     <= done;
            frame_sent <= 1'b0;
            if (rise && state != IDLE) begin
                missed <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (rise) begin
                        state    <= HDR0;
                        tx_data  <= SYNC_BYTE;
                        tx_valid <= 1'b1;
                        busy     <= 1'b1;
                        r_q      <= 6'd1;
                        k_q      <= '0;
                        csum_q   <= 8'h00;
                    end
                end
                HDR0: begin
                    if (xfer) begin
                        state   <= HDR1;
                        tx_data <= {2'b00, n_q};
                    end
                end
                HDR1: begin
                    if (xfer) begin
                        state   <= HDR2;
                        tx_data <= MARKS_PER_RESULT;
                        csum_q  <= csum_next;
                    end
                end
                HDR2: begin
                    if (xfer) begin
                        csum_q <= csum_next;
                        if (n_q == 6'd0) begin
                            state   <= CKSUM;
                            tx_data <= csum_next;
                        end else begin
                            state   <= MARK_HI;
                            tx_data <= mark16[15:8];
                        end
                    end
                end
                MARK_HI: begin
                    if (xfer) begin
                        state   <= MARK_LO;
                        tx_data <= mark16[7:0];
                        csum_q  <= csum_next;
                        if (k_q == KLAST) begin
                            k_q <= '0;
                            r_q <= r_q + 6'd1;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                MARK_LO: begin
                    if (xfer) begin
                        csum_q <= csum_next;
                        if (r_q > n_q) begin
                            state   <= CKSUM;
                            tx_data <= csum_next;
                        end else begin
                            state   <= MARK_HI;
                            tx_data <= mark16[15:8];
                        end
                    end
                end
                CKSUM: begin
                    if (xfer) begin
                        state      <= IDLE;
                        tx_data    <= 8'h00;
                        tx_valid   <= 1'b0;
                        busy       <= 1'b0;
                        frame_sent <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    tx_valid <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mark_result_streamer.sv
// Bench for mark_result_streamer: random marks and handshake patterns checked
// against a frame model built directly from the mark table.
module tb_mark_result_streamer;

    localparam int NP  = 5;
    localparam int NR  = 10;
    localparam int MW  = 9;
    localparam int MPR = NP + 1;
    localparam int TW  = MPR * MW * NR;

    typedef logic [7:0] bq_t[$];

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          done = 1'b0;
    logic [5:0]    numResults = 6'd0;
    logic [TW-1:0] results = '0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          frame_sent;
    logic          missed;

    int checks = 0;
    int errors = 0;
    int marks [1:NR][0:NP];

    mark_result_streamer #(
        .NUMPOSITIONS (NP),
        .NUMRESULTS   (NR),
        .MARKWIDTH    (MW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .done       (done),
        .numResults (numResults),
        .results    (results),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_sent (frame_sent),
        .missed     (missed)
    );

    always #5 clock = ~clock;

    task automatic randomize_marks();
        for (int r = 1; r <= NR; r++)
            for (int k = 0; k <= NP; k++)
                marks[r][k] = int'($urandom_range(0, 511));
    endtask

    task automatic load_results();
        results = '0;
        for (int r = 1; r <= NR; r++)
            for (int k = 0; k <= NP; k++)
                results[TW - ((r - 1) * MPR + k + 1) * MW +: MW] = MW'(marks[r][k]);
    endtask

    function automatic bq_t model_frame(input int nres);
        bq_t q;
        int  n;
        int  sum;
        n   = (nres > NR) ? NR : nres;
        sum = 0;
        q.push_back(8'hA5);
        q.push_back(8'(n));
        q.push_back(8'(MPR));
        for (int r = 1; r <= n; r++)
            for (int k = 0; k <= NP; k++) begin
                q.push_back(8'(marks[r][k] / 256));
                q.push_back(8'(marks[r][k] % 256));
            end
        for (int i = 1; i < q.size(); i++) sum += int'(q[i]);
        q.push_back(8'(sum % 256));
        return q;
    endfunction

    // Drops done for a cycle, raises it, and reports what the DUT shows one cycle later.
    task automatic pulse_done(output logic [7:0] fb, output logic fv);
        done = 1'b0;
        @(negedge clock);
        done = 1'b1;
        @(negedge clock);
        fv   = tx_valid;
        fb   = tx_data;
        done = 1'b0;
    endtask

    // Sink: mode 0 always ready, 1 random ready, 2 ready except 5 stall cycles
    // once stall_at bytes have been accepted.
    task automatic collect(input int mode, input int stall_at, output bq_t got,
                           output int sent_ok, output int hold_bad, output int busy_cycles);
        logic       stalled;
        logic [7:0] held;
        int         stall_left;
        stalled = 1'b0; held = 8'h00; stall_left = 5;
        got = {}; sent_ok = 0; hold_bad = 0; busy_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (frame_sent === 1'b1) begin
                sent_ok = (busy === 1'b0 && tx_valid === 1'b0) ? 1 : 0;
                @(negedge clock);
                if (frame_sent !== 1'b0) sent_ok = 0;
                break;
            end
            if (stalled && (tx_valid !== 1'b1 || tx_data !== held)) hold_bad++;
            if (busy === 1'b1) busy_cycles++;
            case (mode)
                0: tx_ready = 1'b1;
                1: tx_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (got.size() == stall_at && stall_left > 0) begin
                        tx_ready = 1'b0;
                        stall_left--;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
            endcase
            if (tx_valid === 1'b1 && tx_ready === 1'b1) got.push_back(tx_data);
            stalled = (tx_valid === 1'b1 && tx_ready === 1'b0);
            held    = tx_data;
            @(negedge clock);
        end
        tx_ready = 1'b0;
    endtask

    task automatic set_basic_marks();
        randomize_marks();
        marks[1][0] = 0;  marks[1][1] = 1;  marks[1][2] = 4;
        marks[1][3] = 10; marks[1][4] = 12; marks[1][5] = 17;
        numResults = 6'd1;
        load_results();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h want 00", tx_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (frame_sent !== 1'b0) begin errors++; $display("FAIL reset_frame_sent got %b want 0", frame_sent); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL reset_missed got %b want 0", missed); end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [7:0] exp_b [16];
        bq_t got;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        exp_b = '{8'hA5, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                  8'h04, 8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h33};
        set_basic_marks();
        pulse_done(fb, fv);
        checks++; if (fv !== 1'b1 || fb !== 8'hA5) begin errors++; $display("FAIL basic_latency got valid=%b data=%h want valid=1 data=a5", fv, fb); end
        collect(0, 0, got, sent_ok, hold_bad, bc);
        checks++;
        if (got.size() != 16) begin errors++; $display("FAIL basic_len got %0d want 16", got.size()); end
        else foreach (exp_b[i]) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL basic_byte%0d got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (sent_ok != 1) begin errors++; $display("FAIL basic_frame_sent got %0d want 1", sent_ok); end
    endtask

    task automatic test_zero();
        logic [7:0] exp_b [4];
        bq_t got;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        exp_b = '{8'hA5, 8'h00, 8'h06, 8'h06};
        randomize_marks();
        numResults = 6'd0;
        load_results();
        pulse_done(fb, fv);
        collect(0, 0, got, sent_ok, hold_bad, bc);
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL zero_len got %0d want 4", got.size()); end
        else foreach (exp_b[i]) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL zero_byte%0d got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (bc != 4) begin errors++; $display("FAIL zero_busy_cycles got %0d want 4", bc); end
        checks++; if (sent_ok != 1) begin errors++; $display("FAIL zero_frame_sent got %0d want 1", sent_ok); end
    endtask

    task automatic test_large();
        bq_t got, exp_q;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        randomize_marks();
        marks[1][2] = 300;
        numResults = 6'd2;
        load_results();
        exp_q = model_frame(2);
        pulse_done(fb, fv);
        collect(1, 0, got, sent_ok, hold_bad, bc);
        checks++;
        if (got.size() != 28) begin errors++; $display("FAIL large_len got %0d want 28", got.size()); end
        else begin
            checks++; if (got[7] !== 8'h01 || got[8] !== 8'h2C) begin errors++; $display("FAIL large_mark300 got %h %h want 01 2c", got[7], got[8]); end
            foreach (exp_q[i]) begin
                checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL large_byte%0d got %h want %h", i, got[i], exp_q[i]); end
            end
        end
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL large_hold got %0d violations want 0", hold_bad); end
        checks++; if (sent_ok != 1) begin errors++; $display("FAIL large_frame_sent got %0d want 1", sent_ok); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b [16];
        bq_t got;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        exp_b = '{8'hA5, 8'h01, 8'h06, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                  8'h04, 8'h00, 8'h0A, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h33};
        set_basic_marks();
        pulse_done(fb, fv);
        collect(2, 4, got, sent_ok, hold_bad, bc);
        checks++; if (hold_bad != 0) begin errors++; $display("FAIL bp_hold got %0d violations want 0", hold_bad); end
        checks++; if (bc != 21) begin errors++; $display("FAIL bp_busy_cycles got %0d want 21", bc); end
        checks++;
        if (got.size() != 16) begin errors++; $display("FAIL bp_len got %0d want 16", got.size()); end
        else foreach (exp_b[i]) begin
            checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL bp_byte%0d got %h want %h", i, got[i], exp_b[i]); end
        end
        checks++; if (sent_ok != 1) begin errors++; $display("FAIL bp_frame_sent got %0d want 1", sent_ok); end
    endtask

    task automatic test_random();
        bq_t got, exp_q;
        int sent_ok, hold_bad, bc, nres;
        logic [7:0] fb;
        logic fv;
        for (int it = 0; it < 4; it++) begin
            randomize_marks();
            nres = (it == 0) ? 63 : int'($urandom_range(0, 63));
            numResults = 6'(nres);
            load_results();
            exp_q = model_frame(nres);
            pulse_done(fb, fv);
            collect(1, 0, got, sent_ok, hold_bad, bc);
            checks++;
            if (got.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_len got %0d want %0d", it, got.size(), exp_q.size()); end
            else foreach (exp_q[i]) begin
                checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_byte%0d got %h want %h", it, i, got[i], exp_q[i]); end
            end
            checks++; if (hold_bad != 0) begin errors++; $display("FAIL rand%0d_hold got %0d violations want 0", it, hold_bad); end
            checks++; if (sent_ok != 1) begin errors++; $display("FAIL rand%0d_frame_sent got %0d want 1", it, sent_ok); end
        end
    endtask

    task automatic test_missed();
        bq_t got, exp_q, exp2;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        randomize_marks();
        numResults = 6'd3;
        load_results();
        exp_q = model_frame(3);
        pulse_done(fb, fv);
        fork
            collect(1, 0, got, sent_ok, hold_bad, bc);
            begin
                repeat (6) @(negedge clock);
                randomize_marks();
                numResults = 6'd7;
                load_results();
                done = 1'b1;
                repeat (2) @(negedge clock);
                done = 1'b0;
            end
        join
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL missed_len got %0d want %0d", got.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL missed_byte%0d got %h want %h", i, got[i], exp_q[i]); end
        end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_flag got %b want 1", missed); end
        exp2 = model_frame(7);
        pulse_done(fb, fv);
        collect(0, 0, got, sent_ok, hold_bad, bc);
        checks++;
        if (got.size() != exp2.size()) begin errors++; $display("FAIL missed2_len got %0d want %0d", got.size(), exp2.size()); end
        else foreach (exp2[i]) begin
            checks++; if (got[i] !== exp2[i]) begin errors++; $display("FAIL missed2_byte%0d got %h want %h", i, got[i], exp2[i]); end
        end
        checks++; if (missed !== 1'b1) begin errors++; $display("FAIL missed_sticky got %b want 1", missed); end
    endtask

    task automatic test_reset_mid();
        bq_t got, exp_q;
        int sent_ok, hold_bad, bc;
        logic [7:0] fb;
        logic fv;
        randomize_marks();
        numResults = 6'd2;
        load_results();
        exp_q = model_frame(2);
        pulse_done(fb, fv);
        tx_ready = 1'b1;
        repeat (4) @(negedge clock);
        checks++; if (tx_data !== exp_q[4] || tx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pending got %h valid=%b want %h valid=1", tx_data, tx_valid, exp_q[4]); end
        #2;
        reset = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_tx_valid got %b want 0", tx_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (missed !== 1'b0) begin errors++; $display("FAIL rstmid_missed got %b want 0", missed); end
        tx_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        pulse_done(fb, fv);
        checks++; if (fv !== 1'b1 || fb !== 8'hA5) begin errors++; $display("FAIL rstmid_restart got valid=%b data=%h want valid=1 data=a5", fv, fb); end
        collect(0, 0, got, sent_ok, hold_bad, bc);
        checks++;
        if (got.size() != exp_q.size()) begin errors++; $display("FAIL rstmid_len got %0d want %0d", got.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            checks++; if (got[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_byte%0d got %h want %h", i, got[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_large();
        test_backpressure();
        test_random();
        test_missed();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
